// File: rtl/serial_cmd_initiator_pkg.sv
// rtl/serial_cmd_initiator_pkg.sv - opcodes, reply lengths and FSM encoding for the trigger-board command initiator
package serial_cmd_initiator_pkg;

  localparam int BYTE_W       = 8;
  localparam int MAX_ARGS_DEF = 8;
  localparam int MAX_RESP_DEF = 64;

  localparam logic [7:0] CMD_VERSION    = 8'd0;
  localparam logic [7:0] CMD_COINC_TIME = 8'd1;
  localparam logic [7:0] CMD_OUT_ENABLE = 8'd3;
  localparam logic [7:0] CMD_PRESCALE   = 8'd7;
  localparam logic [7:0] CMD_HISTOS     = 8'd10;
  localparam logic [7:0] CMD_TRIGMASK   = 8'd14;
  localparam logic [7:0] CMD_CLOCKCNT   = 8'd16;
  localparam logic [7:0] CMD_STARTTIME  = 8'd18;
  localparam logic [7:0] CMD_NLAYER     = 8'd19;
  localparam logic [7:0] CMD_NHIT       = 8'd20;

  localparam logic [6:0] RLEN_VERSION   = 7'd1;
  localparam logic [6:0] RLEN_HISTOS    = 7'd64;
  localparam logic [6:0] RLEN_CLOCKCNT  = 7'd64;
  localparam logic [6:0] RLEN_STARTTIME = 7'd8;
  localparam logic [6:0] RLEN_WRITE     = 7'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_LOAD,
    ST_TX_HOLD,
    ST_RX,
    ST_FINISH
  } state_t;

  // Read-back commands return data; configuration writes are unacknowledged.
  function automatic logic [6:0] reply_len(input logic [7:0] op);
    case (op)
      CMD_VERSION:   reply_len = RLEN_VERSION;
      CMD_HISTOS:    reply_len = RLEN_HISTOS;
      CMD_CLOCKCNT:  reply_len = RLEN_CLOCKCNT;
      CMD_STARTTIME: reply_len = RLEN_STARTTIME;
      default:       reply_len = RLEN_WRITE;
    endcase
  endfunction

endpackage

// File: rtl/serial_cmd_initiator_if.sv
// rtl/serial_cmd_initiator_if.sv - command, UART and reply-buffer signals of the initiator
interface serial_cmd_initiator_if
  import serial_cmd_initiator_pkg::*;
#(
  parameter int MAX_ARGS = MAX_ARGS_DEF,
  parameter int MAX_RESP = MAX_RESP_DEF
);
  localparam int AW = $clog2(MAX_RESP);

  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [BYTE_W-1:0]          cmd_opcode;
  logic [BYTE_W*MAX_ARGS-1:0] cmd_args;
  logic [3:0]                 cmd_nargs;
  logic [6:0]                 cmd_nresp;
  logic                       txBusy;
  logic                       txStart;
  logic [BYTE_W-1:0]          txData;
  logic                       rxReady;
  logic [BYTE_W-1:0]          rxData;
  logic [AW-1:0]              resp_rd_addr;
  logic [BYTE_W-1:0]          resp_rd_data;
  logic [6:0]                 resp_count;
  logic                       busy;
  logic                       done;
  logic                       timeout;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_args, cmd_nargs, cmd_nresp,
    input  txBusy, rxReady, rxData, resp_rd_addr,
    output cmd_ready, txStart, txData, resp_rd_data, resp_count,
    output busy, done, timeout
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_args, cmd_nargs, cmd_nresp,
    output txBusy, rxReady, rxData, resp_rd_addr,
    input  cmd_ready, txStart, txData, resp_rd_data, resp_count,
    input  busy, done, timeout
  );

endinterface

// File: rtl/serial_resp_buffer.sv
// rtl/serial_resp_buffer.sv - reply byte store, one write port and one combinational read port
module serial_resp_buffer
  import serial_cmd_initiator_pkg::*;
#(
  parameter int DEPTH = MAX_RESP_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  // Contents survive reset so the host can still read the last reply.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/serial_cmd_initiator.sv
// rtl/serial_cmd_initiator.sv - sends opcode plus argument bytes over UART, collects the reply bytes
module serial_cmd_initiator
  import serial_cmd_initiator_pkg::*;
#(
  parameter int MAX_ARGS  = MAX_ARGS_DEF,
  parameter int MAX_RESP  = MAX_RESP_DEF,
  parameter int TO_W      = 24,
  parameter int TO_CYCLES = 5000000
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_cmd_initiator_if.master bus
);

  localparam int              AW        = $clog2(MAX_RESP);
  localparam int              ARG_W     = BYTE_W * MAX_ARGS;
  localparam logic [3:0]      NARGS_MAX = 4'(MAX_ARGS);
  localparam logic [6:0]      NRESP_MAX = 7'(MAX_RESP);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_CYCLES - 1);

  state_t            state, state_n;
  logic [3:0]        idx, nargs_q, nargs_c;
  logic [6:0]        nresp_q, nresp_c, resp_count_q;
  logic [BYTE_W-1:0] opcode_q, txdata_q, cur_byte;
  logic [ARG_W-1:0]  args_q;
  logic [TO_W-1:0]   timer;
  logic              accept, tx_start, store, expire;

  assign nargs_c = (bus.cmd_nargs > NARGS_MAX) ? NARGS_MAX : bus.cmd_nargs;
  assign nresp_c = (bus.cmd_nresp > NRESP_MAX) ? NRESP_MAX : bus.cmd_nresp;

  // args_q shifts down after each argument strobe, so the next argument is always in the low byte.
  assign cur_byte = (idx == 4'd0) ? opcode_q : args_q[BYTE_W-1:0];

  // FINISH lasts one cycle and is excluded so done and timeout can never coincide.
  assign expire = (state != ST_IDLE) && (state != ST_FINISH) && (timer == TO_LAST);

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    tx_start = 1'b0;
    store    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_n = ST_TX_LOAD;
        end
      end
      ST_TX_LOAD: begin
        if (!bus.txBusy) begin
          tx_start = 1'b1;
          state_n  = ST_TX_HOLD;
        end
      end
      ST_TX_HOLD: begin
        if ((idx + 4'd1) <= nargs_q) begin
          state_n = ST_TX_LOAD;
        end else if (nresp_q == 7'd0) begin
          state_n = ST_FINISH;
        end else begin
          state_n = ST_RX;
        end
      end
      ST_RX: begin
        if (bus.rxReady) begin
          store = 1'b1;
          if ((resp_count_q + 7'd1) == nresp_q) begin
            state_n = ST_FINISH;
          end
        end
      end
      ST_FINISH: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
    if (expire) begin
      state_n  = ST_IDLE;
      tx_start = 1'b0;
      store    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= 4'd0;
      nargs_q      <= 4'd0;
      nresp_q      <= 7'd0;
      resp_count_q <= 7'd0;
      opcode_q     <= '0;
      args_q       <= '0;
      txdata_q     <= '0;
      timer        <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        opcode_q     <= bus.cmd_opcode;
        args_q       <= bus.cmd_args;
        nargs_q      <= nargs_c;
        nresp_q      <= nresp_c;
        idx          <= 4'd0;
        resp_count_q <= 7'd0;
        timer        <= '0;
      end else if (state != ST_IDLE) begin
        timer <= (tx_start || store) ? '0 : timer + 1'b1;
      end
      if (tx_start) begin
        txdata_q <= cur_byte;
        if (idx != 4'd0) begin
          args_q <= args_q >> BYTE_W;
        end
      end
      if (state == ST_TX_HOLD) begin
        idx <= idx + 4'd1;
      end
      if (store) begin
        resp_count_q <= resp_count_q + 7'd1;
      end
    end
  end

  serial_resp_buffer #(
    .DEPTH (MAX_RESP),
    .AW    (AW)
  ) u_resp_buffer (
    .clk   (clk),
    .we    (store),
    .waddr (resp_count_q[AW-1:0]),
    .wdata (bus.rxData),
    .raddr (bus.resp_rd_addr),
    .rdata (bus.resp_rd_data)
  );

  assign bus.cmd_ready  = (state == ST_IDLE);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_FINISH);
  assign bus.timeout    = expire;
  assign bus.txStart    = tx_start;
  assign bus.txData     = tx_start ? cur_byte : txdata_q;
  assign bus.resp_count = resp_count_q;

endmodule

// File: tb/tb_serial_cmd_initiator.sv
// tb/tb_serial_cmd_initiator.sv - self-checking bench for serial_cmd_initiator
module tb_serial_cmd_initiator;
  import serial_cmd_initiator_pkg::*;

  localparam int TO_CYC = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_cmd_initiator_if bus ();

  serial_cmd_initiator #(
    .MAX_ARGS  (8),
    .MAX_RESP  (64),
    .TO_W      (24),
    .TO_CYCLES (TO_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // UART transmitter stand-in: busy for busy_len_cfg cycles after each strobe.
  logic force_busy = 1'b0;
  int   busy_len_cfg = 0;
  int   busy_cnt = 0;
  assign bus.txBusy = force_busy || (busy_cnt != 0);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge reset) begin
    if (reset) busy_cnt <= 0;
    else if (bus.txStart) busy_cnt <= busy_len_cfg;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  logic [7:0] tx_log [0:4095];
  int         tx_cyc_log [0:4095];
  int         tx_n = 0;
  int         last_tx_cyc = -100;
  int         spacing_bad = 0;
  int         done_n = 0, done_cyc = 0;
  int         to_n = 0, to_cyc = 0;
  int         both_n = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.txStart) begin
        tx_log[tx_n]     <= bus.txData;
        tx_cyc_log[tx_n] <= cyc;
        if (cyc - last_tx_cyc < 2) spacing_bad <= spacing_bad + 1;
        last_tx_cyc      <= cyc;
        tx_n             <= tx_n + 1;
      end
      if (bus.done) begin
        done_n   <= done_n + 1;
        done_cyc <= cyc;
      end
      if (bus.timeout) begin
        to_n   <= to_n + 1;
        to_cyc <= cyc;
      end
      if (bus.done && bus.timeout) both_n <= both_n + 1;
    end
  end

  // Reference picture of the reply buffer: what each address should hold.
  logic [7:0] exp_buf   [0:63];
  bit         exp_valid [0:63];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_txStart"}, 64'(bus.txStart), 64'd0);
    check({nm, "_txData"}, 64'(bus.txData), 64'd0);
    check({nm, "_busy"}, 64'(bus.busy), 64'd0);
    check({nm, "_done"}, 64'(bus.done), 64'd0);
    check({nm, "_timeout"}, 64'(bus.timeout), 64'd0);
    check({nm, "_resp_count"}, 64'(bus.resp_count), 64'd0);
    check({nm, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
  endtask

  task automatic check_buffer(input string nm);
    for (int i = 0; i < 64; i++) begin
      if (exp_valid[i]) begin
        bus.resp_rd_addr = 6'(i);
        #1;
        check($sformatf("%s_buf%0d", nm, i), 64'(bus.resp_rd_data), 64'(exp_buf[i]));
      end
    end
  endtask

  task automatic issue_cmd(input logic [7:0] op, input logic [63:0] args, input logic [3:0] na,
                           input logic [6:0] nr, output int acc);
    bit ok;
    ok = 1'b0;
    bus.cmd_opcode = op;
    bus.cmd_args   = args;
    bus.cmd_nargs  = na;
    bus.cmd_nresp  = nr;
    bus.cmd_valid  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    acc = cyc;
    tick();
    bus.cmd_valid = 1'b0;
    check("cmd_accept", 64'(ok), 64'd1);
  endtask

  // One complete command against the model: wire bytes are the opcode then
  // min(nargs,8) args low byte first; the first min(nreply,nresp) reply bytes
  // land in the buffer; done one cycle after the last needed byte, otherwise a
  // timeout TO_CYC cycles after the last byte of progress.
  task automatic run_cmd(input string nm, input logic [7:0] op, input logic [63:0] args,
                         input int nargs, input int nresp, input int nreply, input int gap,
                         input int force_len, input int ublen, input int base, input bit rnd);
    int nargs_c, nresp_c, ntx, tx0, d0, t0, sb0, acc, last_prog, last_strobe, stored, got;
    bit exp_done;
    logic [7:0] v;
    logic [7:0] exp_b;
    nargs_c = (nargs > 8) ? 8 : nargs;
    nresp_c = (nresp > 64) ? 64 : nresp;
    ntx = nargs_c + 1;
    tx0 = tx_n;
    d0 = done_n;
    t0 = to_n;
    sb0 = spacing_bad;
    stored = 0;
    busy_len_cfg = ublen;
    force_busy = (force_len > 0);
    issue_cmd(op, args, 4'(nargs), 7'(nresp), acc);
    if (force_len > 0) begin
      repeat (force_len) tick();
      force_busy = 1'b0;
    end
    for (int k = 0; k < 3000 && (tx_n - tx0) < ntx && to_n == t0; k++) tick();
    got = tx_n - tx0;
    check({nm, "_txcount"}, 64'(got), 64'(ntx));
    for (int i = 0; i < ntx && i < got; i++) begin
      exp_b = (i == 0) ? op : args[8*(i-1) +: 8];
      check($sformatf("%s_txbyte%0d", nm, i), 64'(tx_log[tx0+i]), 64'(exp_b));
    end
    last_strobe = acc;
    if (got > 0) begin
      check({nm, "_first_latency"}, 64'(tx_cyc_log[tx0] - acc), 64'(1 + force_len));
      last_strobe = tx_cyc_log[tx0 + got - 1];
    end
    last_prog = last_strobe;
    for (int i = 0; i < nreply; i++) begin
      repeat (gap) tick();
      v = rnd ? 8'($urandom) : 8'(base + i);
      bus.rxReady = 1'b1;
      bus.rxData  = v;
      if (i < nresp_c) begin
        exp_buf[i]   = v;
        exp_valid[i] = 1'b1;
        stored++;
        last_prog = cyc;
      end
      tick();
      bus.rxReady = 1'b0;
    end
    for (int k = 0; k < TO_CYC + 200 && done_n == d0 && to_n == t0; k++) tick();
    repeat (3) tick();
    exp_done = (nreply >= nresp_c);
    check({nm, "_done_pulses"}, 64'(done_n - d0), exp_done ? 64'd1 : 64'd0);
    check({nm, "_timeout_pulses"}, 64'(to_n - t0), exp_done ? 64'd0 : 64'd1);
    if (exp_done && done_n > d0)
      check({nm, "_done_cycle"}, 64'(done_cyc),
            64'((nresp_c == 0) ? last_strobe + 2 : last_prog + 1));
    if (!exp_done && to_n > t0)
      check({nm, "_timeout_cycle"}, 64'(to_cyc), 64'(last_prog + TO_CYC));
    check({nm, "_resp_count"}, 64'(bus.resp_count), 64'(stored));
    check({nm, "_spacing"}, 64'(spacing_bad - sb0), 64'd0);
    check_buffer(nm);
  endtask

  initial begin
    int acc, d0, t0, na, nr, nrc, mode, nrep;
    bus.cmd_valid    = 1'b0;
    bus.cmd_opcode   = 8'd0;
    bus.cmd_args     = 64'd0;
    bus.cmd_nargs    = 4'd0;
    bus.cmd_nresp    = 7'd0;
    bus.rxReady      = 1'b0;
    bus.rxData       = 8'd0;
    bus.resp_rd_addr = 6'd0;
    for (int i = 0; i < 64; i++) exp_valid[i] = 1'b0;

    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_idle_outputs("reset");

    run_cmd("version", CMD_VERSION, 64'd0, 0, 1, 1, 1, 0, 0, 8, 1'b0);
    run_cmd("trigmask", CMD_TRIGMASK, 64'h0123456789ABCDEF, 8, 0, 0, 1, 0, 1, 0, 1'b0);
    run_cmd("clockcnt", CMD_CLOCKCNT, 64'd0, 0, 64, 64, 1, 0, 0, 0, 1'b0);
    run_cmd("txbusy10", CMD_PRESCALE, 64'h00000000_0000A55A, 2, 0, 0, 1, 10, 2, 0, 1'b0);
    run_cmd("timeout", CMD_HISTOS, 64'd0, 0, 7, 3, 2, 0, 0, 8'hC0, 1'b0);

    // Stray byte in IDLE must leave the count and buffer alone.
    tick();
    bus.rxReady = 1'b1;
    bus.rxData  = 8'hA5;
    tick();
    bus.rxReady = 1'b0;
    repeat (2) tick();
    check("stray_resp_count", 64'(bus.resp_count), 64'd3);
    check_buffer("stray");

    run_cmd("clamp", CMD_NHIT, 64'hFEDCBA98_76543210, 15, 127, 66, 1, 0, 1, 0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      na   = int'($urandom_range(0, 15));
      nr   = int'($urandom_range(0, 70));
      nrc  = (nr > 64) ? 64 : nr;
      mode = int'($urandom_range(0, 2));
      if (mode == 0 || nrc == 0) nrep = nrc;
      else if (mode == 1) nrep = nrc + 2;
      else nrep = int'($urandom_range(0, nrc - 1));
      run_cmd($sformatf("rnd%0d", r), 8'($urandom), {$urandom, $urandom}, na, nr, nrep,
              int'($urandom_range(1, 3)), 0, int'($urandom_range(0, 3)), 0, 1'b1);
    end

    // Reset in the middle of a long transmit.
    busy_len_cfg = 3;
    issue_cmd(CMD_TRIGMASK, {$urandom, $urandom}, 4'd8, 7'd0, acc);
    repeat (5) tick();
    check("midreset_busy_before", 64'(bus.busy), 64'd1);
    d0 = done_n;
    t0 = to_n;
    reset = 1'b1;
    #1;
    check_idle_outputs("midreset");
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
    check_idle_outputs("after_reset");
    check("midreset_done_pulses", 64'(done_n - d0), 64'd0);
    check("midreset_timeout_pulses", 64'(to_n - t0), 64'd0);

    check("done_timeout_exclusive", 64'(both_n), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
